// File: rtl/vx_rop_blend_factor.sv
// Blend-factor stage: derives src/dst unorm8 factors from the four blend-func codes
// and forwards colors, factors and tag through a 2-deep valid/ready pipeline.
`ifndef ROP_BLEND_FUNC_BITS
`define ROP_BLEND_FUNC_BITS 4
`endif

module vx_rop_blend_factor #(
   parameter int TAG_WIDTH = 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            valid_in,
   output logic                            ready_in,
   input  logic [TAG_WIDTH-1:0]            tag_in,
   input  logic [`ROP_BLEND_FUNC_BITS-1:0] func_src_rgb,
   input  logic [`ROP_BLEND_FUNC_BITS-1:0] func_src_a,
   input  logic [`ROP_BLEND_FUNC_BITS-1:0] func_dst_rgb,
   input  logic [`ROP_BLEND_FUNC_BITS-1:0] func_dst_a,
   input  logic [31:0]                     blend_const,
   input  logic [31:0]                     src_color,
   input  logic [31:0]                     dst_color,
   output logic                            valid_out,
   input  logic                            ready_out,
   output logic [TAG_WIDTH-1:0]            tag_out,
   output logic [31:0]                     src_color_out,
   output logic [31:0]                     dst_color_out,
   output logic [31:0]                     src_factor,
   output logic [31:0]                     dst_factor
);

   localparam int FB = `ROP_BLEND_FUNC_BITS;

   // rgba_t byte layout: a[31:24] r[23:16] g[15:8] b[7:0]
   function automatic logic [7:0] blend_ch(
      input logic [FB-1:0] code,
      input logic [7:0]    s,
      input logic [7:0]    d,
      input logic [7:0]    c,
      input logic [7:0]    sa,
      input logic [7:0]    da,
      input logic [7:0]    ca,
      input logic          is_a
   );
      logic [7:0] r;
      logic [7:0] inv_da;
      inv_da = 8'hFF - da;
      case (code)
         FB'(0):  r = 8'h00;
         FB'(1):  r = 8'hFF;
         FB'(2):  r = s;
         FB'(3):  r = 8'hFF - s;
         FB'(4):  r = d;
         FB'(5):  r = 8'hFF - d;
         FB'(6):  r = sa;
         FB'(7):  r = 8'hFF - sa;
         FB'(8):  r = da;
         FB'(9):  r = inv_da;
         FB'(10): r = c;
         FB'(11): r = 8'hFF - c;
         FB'(12): r = ca;
         FB'(13): r = 8'hFF - ca;
         FB'(14): r = is_a ? 8'hFF : ((sa < inv_da) ? sa : inv_da);
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   logic                 rdy_q;
   logic                 s1_v_q, s2_v_q;
   logic [TAG_WIDTH-1:0] s1_tag_q, s2_tag_q;
   logic [FB-1:0]        s1_fsr_q, s1_fsa_q, s1_fdr_q, s1_fda_q;
   logic [31:0]          s1_c_q, s1_s_q, s1_d_q;
   logic [31:0]          s2_s_q, s2_d_q, s2_sf_q, s2_df_q;
   logic [31:0]          sf_d, df_d;
   logic                 en1, en2, acc;

   assign en2      = !s2_v_q || ready_out;
   assign en1      = !s1_v_q || en2;
   assign ready_in = rdy_q && en1;
   assign acc      = valid_in && ready_in;

   always_comb begin
      sf_d = '0;
      df_d = '0;
      for (int i = 0; i < 3; i++) begin
         sf_d[i*8 +: 8] = blend_ch(s1_fsr_q, s1_s_q[i*8 +: 8], s1_d_q[i*8 +: 8],
                                   s1_c_q[i*8 +: 8], s1_s_q[31:24], s1_d_q[31:24],
                                   s1_c_q[31:24], 1'b0);
         df_d[i*8 +: 8] = blend_ch(s1_fdr_q, s1_s_q[i*8 +: 8], s1_d_q[i*8 +: 8],
                                   s1_c_q[i*8 +: 8], s1_s_q[31:24], s1_d_q[31:24],
                                   s1_c_q[31:24], 1'b0);
      end
      // On alpha the colour operand is the .a byte itself
      sf_d[31:24] = blend_ch(s1_fsa_q, s1_s_q[31:24], s1_d_q[31:24], s1_c_q[31:24],
                             s1_s_q[31:24], s1_d_q[31:24], s1_c_q[31:24], 1'b1);
      df_d[31:24] = blend_ch(s1_fda_q, s1_s_q[31:24], s1_d_q[31:24], s1_c_q[31:24],
                             s1_s_q[31:24], s1_d_q[31:24], s1_c_q[31:24], 1'b1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdy_q    <= 1'b0;
         s1_v_q   <= 1'b0;
         s2_v_q   <= 1'b0;
         s1_tag_q <= '0;
         s1_fsr_q <= '0;
         s1_fsa_q <= '0;
         s1_fdr_q <= '0;
         s1_fda_q <= '0;
         s1_c_q   <= '0;
         s1_s_q   <= '0;
         s1_d_q   <= '0;
         s2_tag_q <= '0;
         s2_s_q   <= '0;
         s2_d_q   <= '0;
         s2_sf_q  <= '0;
         s2_df_q  <= '0;
      end else begin
         rdy_q <= 1'b1;
         if (en1) begin
            s1_v_q <= acc;
         end
         if (acc) begin
            s1_tag_q <= tag_in;
            s1_fsr_q <= func_src_rgb;
            s1_fsa_q <= func_src_a;
            s1_fdr_q <= func_dst_rgb;
            s1_fda_q <= func_dst_a;
            s1_c_q   <= blend_const;
            s1_s_q   <= src_color;
            s1_d_q   <= dst_color;
         end
         if (en2) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
               s2_tag_q <= s1_tag_q;
               s2_s_q   <= s1_s_q;
               s2_d_q   <= s1_d_q;
               s2_sf_q  <= sf_d;
               s2_df_q  <= df_d;
            end
         end
      end
   end

   assign valid_out     = s2_v_q;
   assign tag_out       = s2_tag_q;
   assign src_color_out = s2_s_q;
   assign dst_color_out = s2_d_q;
   assign src_factor    = s2_sf_q;
   assign dst_factor    = s2_df_q;

endmodule

// File: tb/tb_vx_rop_blend_factor.sv
// Directed bench for vx_rop_blend_factor: factor table vectors, stalled
// streaming with a tag scoreboard, and async reset mid-stream.
module tb_vx_rop_blend_factor;

   localparam int TW = 3;

   localparam logic [3:0] ZERO = 4'd0, ONE = 4'd1, SRC_RGB = 4'd2, OM_SRC_RGB = 4'd3;
   localparam logic [3:0] DST_RGB = 4'd4, OM_DST_RGB = 4'd5, SRC_A = 4'd6, OM_SRC_A = 4'd7;
   localparam logic [3:0] DST_A = 4'd8, OM_DST_A = 4'd9, CONST_RGB = 4'd10;
   localparam logic [3:0] OM_CONST_RGB = 4'd11, CONST_A = 4'd12, OM_CONST_A = 4'd13;
   localparam logic [3:0] ALPHA_SAT = 4'd14, UNUSED = 4'd15;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          valid_in = 1'b0;
   logic          ready_in;
   logic [TW-1:0] tag_in = '0;
   logic [3:0]    func_src_rgb = '0, func_src_a = '0, func_dst_rgb = '0, func_dst_a = '0;
   logic [31:0]   blend_const = '0, src_color = '0, dst_color = '0;
   logic          valid_out;
   logic          ready_out = 1'b0;
   logic [TW-1:0] tag_out;
   logic [31:0]   src_color_out, dst_color_out, src_factor, dst_factor;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   vx_rop_blend_factor #(.TAG_WIDTH(TW)) dut (
      .clk(clk), .reset(reset),
      .valid_in(valid_in), .ready_in(ready_in), .tag_in(tag_in),
      .func_src_rgb(func_src_rgb), .func_src_a(func_src_a),
      .func_dst_rgb(func_dst_rgb), .func_dst_a(func_dst_a),
      .blend_const(blend_const), .src_color(src_color), .dst_color(dst_color),
      .valid_out(valid_out), .ready_out(ready_out), .tag_out(tag_out),
      .src_color_out(src_color_out), .dst_color_out(dst_color_out),
      .src_factor(src_factor), .dst_factor(dst_factor)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [3:0]  fsr, fsa, fdr, fda;
      logic [31:0] c, s, d, esf, edf;
   } vec_t;

   vec_t vt[10];

   task automatic run_vec(input int i);
      @(negedge clk);
      func_src_rgb = vt[i].fsr; func_src_a = vt[i].fsa;
      func_dst_rgb = vt[i].fdr; func_dst_a = vt[i].fda;
      blend_const = vt[i].c; src_color = vt[i].s; dst_color = vt[i].d;
      tag_in = TW'(i);
      valid_in = 1'b1;
      ready_out = 1'b0;
      #1 check($sformatf("v%0d_rdy_in", i), 32'(ready_in), 32'd1);
      @(posedge clk);
      #1 valid_in = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_vout", i), 32'(valid_out), 32'd1);
      check($sformatf("v%0d_sf", i), src_factor, vt[i].esf);
      check($sformatf("v%0d_df", i), dst_factor, vt[i].edf);
      check($sformatf("v%0d_scol", i), src_color_out, vt[i].s);
      check($sformatf("v%0d_dcol", i), dst_color_out, vt[i].d);
      check($sformatf("v%0d_tag", i), 32'(tag_out), 32'(i % 8));
      ready_out = 1'b1;
      @(posedge clk);
      #1 check($sformatf("v%0d_drain", i), 32'(valid_out), 32'd0);
   endtask

   initial begin
      // fsr fsa fdr fda const src dst exp_sf exp_df
      vt[0] = '{ONE, ONE, ZERO, ZERO, 32'h0, 32'h11223344, 32'h0,
                32'hFFFFFFFF, 32'h00000000};
      vt[1] = '{SRC_A, SRC_A, OM_SRC_A, OM_SRC_A, 32'h0, 32'h40102030, 32'h0,
                32'h40404040, 32'hBFBFBFBF};
      vt[2] = '{ALPHA_SAT, ONE, ZERO, ALPHA_SAT, 32'h0, 32'hC0010203, 32'h80445566,
                32'hFF7F7F7F, 32'hFF000000};
      vt[3] = '{CONST_RGB, CONST_RGB, OM_CONST_A, OM_CONST_A, 32'hF0102030, 32'h0, 32'h0,
                32'hF0102030, 32'h0F0F0F0F};
      vt[4] = '{DST_RGB, DST_A, OM_DST_RGB, OM_DST_RGB, 32'h0, 32'h0, 32'hA0B0C0D0,
                32'hA0B0C0D0, 32'h5F4F3F2F};
      vt[5] = '{OM_SRC_RGB, OM_SRC_RGB, UNUSED, UNUSED, 32'h0, 32'h11223344, 32'h0,
                32'hEEDDCCBB, 32'h00000000};
      vt[6] = '{OM_CONST_RGB, OM_CONST_RGB, CONST_A, CONST_A, 32'hF0102030, 32'h0, 32'h0,
                32'h0FEFDFCF, 32'hF0F0F0F0};
      vt[7] = '{SRC_RGB, SRC_RGB, OM_DST_A, OM_DST_A, 32'h0, 32'h11223344, 32'hA0000000,
                32'h11223344, 32'h5F5F5F5F};
      vt[8] = '{ALPHA_SAT, ALPHA_SAT, DST_A, ZERO, 32'h0, 32'h30000000, 32'h10000000,
                32'hFF303030, 32'h00101010};
      vt[9] = '{OM_DST_RGB, ONE, SRC_RGB, OM_SRC_A, 32'h0, 32'h00FF0080, 32'h00FF0001,
                32'hFF00FFFE, 32'hFFFF0080};
   end

   int q[$];
   int sent, recv, occ, cyc;
   logic acc, drn, held;
   logic [31:0] h_sf, h_tag;

   initial begin
      #2;
      check("rst_vout", 32'(valid_out), 32'd0);
      check("rst_sf", src_factor, 32'd0);
      check("rst_rdy", 32'(ready_in), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1 check("rel_rdy_pre_edge", 32'(ready_in), 32'd0);
      @(posedge clk);
      #1 check("rel_rdy_post_edge", 32'(ready_in), 32'd1);

      for (int i = 0; i < 10; i++) run_vec(i);

      // streaming: 8 fragments, downstream stalled on cycles 3..5
      func_src_rgb = SRC_RGB; func_src_a = SRC_RGB;
      func_dst_rgb = OM_SRC_RGB; func_dst_a = OM_SRC_RGB;
      blend_const = '0; dst_color = '0;
      sent = 0; recv = 0; occ = 0; cyc = 0; held = 1'b0;
      while (recv < 8 && cyc < 40) begin
         @(negedge clk);
         ready_out = !(cyc >= 3 && cyc <= 5);
         valid_in = (sent < 8);
         tag_in = TW'(sent);
         src_color = 32'h01020304 * (sent + 1);
         #1;
         check($sformatf("st%0d_rdy_in", cyc), 32'(ready_in),
               32'((occ < 2) || ready_out));
         if (held) begin
            check($sformatf("st%0d_hold_v", cyc), 32'(valid_out), 32'd1);
            check($sformatf("st%0d_hold_sf", cyc), src_factor, h_sf);
            check($sformatf("st%0d_hold_tag", cyc), 32'(tag_out), h_tag);
         end
         check($sformatf("st%0d_vout", cyc), 32'(valid_out), 32'(occ > 0 && cyc > 1));
         if (valid_out) begin
            if (q.size() == 0) begin
               check($sformatf("st%0d_spurious", cyc), 32'(valid_out), 32'd0);
            end else begin
               check($sformatf("st%0d_tag", cyc), 32'(tag_out), 32'(q[0]));
               check($sformatf("st%0d_sf", cyc), src_factor, 32'h01020304 * (q[0] + 1));
               check($sformatf("st%0d_df", cyc), dst_factor, ~(32'h01020304 * (q[0] + 1)));
            end
         end
         held = valid_out && !ready_out;
         h_sf = src_factor;
         h_tag = 32'(tag_out);
         acc = valid_in && ready_in;
         drn = valid_out && ready_out;
         @(posedge clk);
         if (acc) begin
            q.push_back(sent);
            sent++;
         end
         if (drn && q.size() > 0) begin
            void'(q.pop_front());
            recv++;
         end
         occ = occ + int'(acc) - int'(drn);
         cyc++;
      end
      check("st_all_received", 32'(recv), 32'd8);
      #1 valid_in = 1'b0;

      // async reset with two fragments in flight
      @(negedge clk);
      ready_out = 1'b0;
      func_src_rgb = ONE; func_src_a = ONE;
      src_color = 32'hDEADBEEF;
      valid_in = 1'b1;
      @(posedge clk);
      #1 src_color = 32'hCAFEF00D;
      @(posedge clk);
      #1 valid_in = 1'b0;
      check("rs_full_vout", 32'(valid_out), 32'd1);
      check("rs_full_rdy", 32'(ready_in), 32'd0);
      #1 reset = 1'b0;
      valid_in = 1'b1;
      #1;
      check("rs_vout_now", 32'(valid_out), 32'd0);
      check("rs_sf_zero", src_factor, 32'd0);
      check("rs_scol_zero", src_color_out, 32'd0);
      @(posedge clk);
      @(negedge clk);
      valid_in = 1'b0;
      reset = 1'b1;
      ready_out = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("rs_stale%0d", k), 32'(valid_out), 32'd0);
      end
      check("rs_rdy_after", 32'(ready_in), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
